microtile_io_arbiter: RTL and testbench
=======================================

Name: microtile_io_arbiter

Overview:
- Shares one 8-bit microtile I/O port (ui_in into the tile, uo_out back) between N_TILES requesters by time multiplexing.
- Each requester posts an 8-bit input vector. The arbiter grants round-robin, drives the vector and the tile select onto the shared bus, and waits a settle time.
- It then samples the tile's 8-bit output and returns it, tagged with the requester id, as a one-cycle response.
- Sits between harness/debug logic and the shared microtile pin mux.

Parameters:
- N_TILES, 4, number of requesters/tiles; 2..16.
- SETTLE_CYCLES, 2, cycles from drive to sample; minimum 1.
- ID_W, $clog2(N_TILES), width of the tile select and response id.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  when 0, no new grants are made; an in-flight transaction still completes.
- req  in  N_TILES  level request per requester.
- req_data  in  8*N_TILES  requester i's input vector in bits [8i+7:8i].
- tile_sel  out  ID_W  selects the tile on the shared bus.
- tile_ui_in  out  8  vector driven to the selected tile.
- tile_uo_out  in  8  selected tile's output.
- rsp_valid  out  1  one-cycle pulse: response available.
- rsp_id  out  ID_W  requester the response belongs to.
- rsp_data  out  8  sampled tile_uo_out.
- busy  out  1  high while a transaction is in flight (state APPLY).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; tile_sel, tile_ui_in, rsp_valid, rsp_id, rsp_data, busy all 0; round-robin pointer ptr=0; settle counter=0.
  - Reset mid-transaction aborts it: no response is issued.
- States: IDLE and APPLY. All outputs are registered.
- IDLE, on a rising edge with ena=1 and eligible request mask non-zero:
  - Eligible mask = req with bit rsp_id cleared when rsp_valid=1. This prevents re-granting the requester that is seeing its response this cycle.
  - Winner = first eligible index at or after ptr, searching upward with wrap modulo N_TILES.
  - On that edge: tile_sel<=winner; tile_ui_in<=req_data[winner]; cnt<=SETTLE_CYCLES-1; state<=APPLY.
- APPLY, each edge:
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: rsp_data<=tile_uo_out; rsp_id<=tile_sel; rsp_valid<=1; ptr<=(tile_sel+1) mod N_TILES; state<=IDLE.
  - req and req_data are ignored; deasserting req mid-transaction does not cancel it.
- rsp_valid is high for exactly one cycle and is cleared on the next edge.
- Latency: grant edge E0, sample edge E0+SETTLE_CYCLES. rsp_valid is high in the cycle after the sample edge.
- Throughput: one transaction per SETTLE_CYCLES+1 cycles with continuous requests.
- tile_sel and tile_ui_in hold their last values in IDLE; they never return to 0 between transactions, so the tile never sees a glitch.
- busy = (state==APPLY).
- ena=0 in IDLE: stays IDLE, ptr unchanged. ena is ignored in APPLY.
- Requester handshake: hold req and req_data stable until rsp_valid with a matching rsp_id. Holding req beyond that cycle means it requests again.
- ptr wraps from N_TILES-1 to 0. For N_TILES not a power of two, the wrap is explicit.

Decomposition:
- Package microtile_arb_pkg:
  - state enum {IDLE, APPLY};
  - localparam IO_W=8.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: mask[N_TILES], ptr[ID_W].
  - Outputs: any, idx[ID_W].
  - Implemented by rotate, priority-encode, add ptr modulo N_TILES.

Test Plan:
- Reset, then single request: req=0001, req_data[0]=0xA5, tile model echoes ~ui_in.
  - tile_sel=0 and tile_ui_in=0xA5 after the grant edge.
  - rsp_valid pulses 2 edges later with rsp_id=0, rsp_data=0x5A.
  - rsp_valid low on the next cycle.
- All four requesting continuously, req=1111:
  - grants in order 0,1,2,3,0, one every 3 cycles (SETTLE_CYCLES=2);
  - each rsp_data matches its own req_data.
- Fairness after wrap: after serving tile 2, req=0101 -> tile 0 is granted next (ptr=3 wraps to 0), not tile 2.
- Back-to-back same requester: req=0010 held across rsp_valid -> the rsp_valid cycle does not regrant; regrant happens on the following edge; no duplicate response.
- ena=0 during APPLY of tile 1:
  - transaction completes with a response;
  - afterwards no grant while ena=0 despite req=1111;
  - setting ena=1 grants tile 2.
- rst_n pulsed low mid-APPLY:
  - all outputs 0 immediately (asynchronous), no rsp_valid;
  - after release, the first grant starts from ptr=0.

Source files
------------

// File: rtl/microtile_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : microtile_arb_pkg
// Purpose  : Shared types and constants for the microtile I/O arbiter.
//            IO_W    - width of the tile ui_in / uo_out vectors
//            state_e - arbiter FSM state encoding
// Revision : 1.0 - initial release
// ============================================================================
package microtile_arb_pkg;

  localparam int IO_W = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_e;

endpackage : microtile_arb_pkg
`default_nettype wire

// File: rtl/microtile_io_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker. Finds the first set bit of
//            mask at or after ptr, searching upward with wrap modulo N_TILES.
// Ports    : mask [N_TILES] - eligible requesters
//            ptr  [ID_W]    - highest-priority index this round
//            any            - at least one bit of mask is set
//            idx  [ID_W]    - winning index (valid when any=1)
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N_TILES = 4,
  parameter int ID_W    = $clog2(N_TILES)
) (
  input  logic [N_TILES-1:0] mask,
  input  logic [ID_W-1:0]    ptr,
  output logic               any,
  output logic [ID_W-1:0]    idx
);

  // One extra bit so ptr+offset (at most 2*N_TILES-2) never overflows.
  localparam logic [ID_W:0] N_EXT = (ID_W+1)'(N_TILES);

  logic [2*N_TILES-1:0] dbl;
  logic [N_TILES-1:0]   rot;
  logic [ID_W:0]        off;
  logic [ID_W:0]        sum;

  always_comb begin
    // Shifting the doubled mask rotates it so that bit ptr lands at bit 0.
    dbl = {mask, mask} >> ptr;
    rot = dbl[N_TILES-1:0];
    any = |mask;
    off = '0;
    for (int i = N_TILES - 1; i >= 0; i--) begin
      if (rot[i]) off = (ID_W+1)'(i);
    end
    sum = {1'b0, ptr} + off;
    // Explicit wrap: N_TILES need not be a power of two.
    if (sum >= N_EXT) sum = sum - N_EXT;
    idx = sum[ID_W-1:0];
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/microtile_io_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : microtile_io_arbiter
// Purpose  : Time-multiplexes one 8-bit microtile I/O port between N_TILES
//            requesters. Grants round-robin, drives the requester's vector
//            and tile select, waits SETTLE_CYCLES, samples the tile output
//            and returns it as a one-cycle tagged response.
// Ports    : clk, rst_n        - clock / async active-low reset
//            ena               - allow new grants
//            req, req_data     - per-requester level request and vector
//            tile_sel,
//            tile_ui_in        - shared bus toward the tile pin mux
//            tile_uo_out       - selected tile output
//            rsp_valid, rsp_id,
//            rsp_data          - one-cycle response
//            busy              - transaction in flight
// Revision : 1.0 - initial release
// ============================================================================
module microtile_io_arbiter
  import microtile_arb_pkg::*;
#(
  parameter int N_TILES       = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int ID_W          = $clog2(N_TILES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [N_TILES-1:0]      req,
  input  logic [IO_W*N_TILES-1:0] req_data,
  output logic [ID_W-1:0]         tile_sel,
  output logic [IO_W-1:0]         tile_ui_in,
  input  logic [IO_W-1:0]         tile_uo_out,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [IO_W-1:0]         rsp_data,
  output logic                    busy
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   tile_sel_q, tile_sel_d;
  logic [IO_W-1:0]   tile_ui_in_q, tile_ui_in_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [IO_W-1:0]   rsp_data_q, rsp_data_d;
  logic              busy_q, busy_d;

  logic [N_TILES-1:0] elig;
  logic               pick_any;
  logic [ID_W-1:0]    pick_idx;
  logic [IO_W-1:0]    pick_data;

  // The requester currently seeing its response is masked out so a held
  // req is treated as a fresh request only from the following cycle.
  always_comb begin
    for (int i = 0; i < N_TILES; i++) begin
      elig[i] = req[i] & ~(rsp_valid_q && (rsp_id_q == ID_W'(i)));
    end
  end

  rr_pick #(
    .N_TILES (N_TILES),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .mask (elig),
    .ptr  (ptr_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < N_TILES; i++) begin
      if (pick_idx == ID_W'(i)) pick_data = req_data[IO_W*i +: IO_W];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    tile_sel_d   = tile_sel_q;
    tile_ui_in_d = tile_ui_in_q;
    rsp_valid_d  = 1'b0;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (ena && pick_any) begin
          tile_sel_d   = pick_idx;
          tile_ui_in_d = pick_data;
          cnt_d        = CNT_W'(SETTLE_CYCLES - 1);
          state_d      = APPLY;
        end
      end
      APPLY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rsp_data_d  = tile_uo_out;
          rsp_id_d    = tile_sel_q;
          rsp_valid_d = 1'b1;
          ptr_d       = (tile_sel_q == ID_W'(N_TILES - 1)) ? '0 : tile_sel_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == APPLY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ptr_q        <= '0;
      tile_sel_q   <= '0;
      tile_ui_in_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      tile_sel_q   <= tile_sel_d;
      tile_ui_in_q <= tile_ui_in_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      busy_q       <= busy_d;
    end
  end

  assign tile_sel   = tile_sel_q;
  assign tile_ui_in = tile_ui_in_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign busy       = busy_q;

endmodule : microtile_io_arbiter
`default_nettype wire

// File: tb/tb_microtile_io_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_microtile_io_arbiter
// Purpose  : Directed self-checking bench for microtile_io_arbiter with
//            N_TILES=4, SETTLE_CYCLES=2. The tile model returns ~ui_in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_microtile_io_arbiter;

  localparam int N_TILES       = 4;
  localparam int SETTLE_CYCLES = 2;
  localparam int ID_W          = 2;

  logic              clk;
  logic              rst_n;
  logic              ena;
  logic [3:0]        req;
  logic [31:0]       req_data;
  logic [ID_W-1:0]   tile_sel;
  logic [7:0]        tile_ui_in;
  logic [7:0]        tile_uo_out;
  logic              rsp_valid;
  logic [ID_W-1:0]   rsp_id;
  logic [7:0]        rsp_data;
  logic              busy;

  int n_vec;
  int n_err;

  microtile_io_arbiter #(
    .N_TILES       (N_TILES),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .ID_W          (ID_W)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .req         (req),
    .req_data    (req_data),
    .tile_sel    (tile_sel),
    .tile_ui_in  (tile_ui_in),
    .tile_uo_out (tile_uo_out),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .busy        (busy)
  );

  assign tile_uo_out = ~tile_ui_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    ena   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Expect a response on this cycle for requester id with tile output d.
  task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [7:0] d);
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_id"}, {30'd0, rsp_id}, {30'd0, id});
    chk({tag, "_data"}, {24'd0, rsp_data}, {24'd0, d});
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    ena      = 1'b0;
    req      = 4'b0000;
    req_data = 32'h0;
    #1;

    // ---- reset state ----
    do_reset();
    chk("rst_tile_sel", {30'd0, tile_sel}, 32'd0);
    chk("rst_ui_in", {24'd0, tile_ui_in}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // ---- single request ----
    req = 4'b0001;
    req_data = 32'h000000A5;
    step();
    chk("t1_sel", {30'd0, tile_sel}, 32'd0);
    chk("t1_ui", {24'd0, tile_ui_in}, 32'hA5);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_nrsp0", {31'd0, rsp_valid}, 32'd0);
    step();
    chk("t1_nrsp1", {31'd0, rsp_valid}, 32'd0);
    step();
    chk_rsp("t1_rsp", 2'd0, 8'h5A);
    chk("t1_busy_end", {31'd0, busy}, 32'd0);
    req = 4'b0000;
    step();
    chk("t1_pulse", {31'd0, rsp_valid}, 32'd0);
    chk("t1_hold_ui", {24'd0, tile_ui_in}, 32'hA5);

    // ---- all four requesting ----
    do_reset();
    req = 4'b1111;
    req_data = 32'h44332211;
    for (int k = 0; k < 5; k++) begin
      logic [1:0] w;
      logic [7:0] d;
      w = 2'(k % 4);
      d = 8'(8'h11 * (w + 1));
      step();
      chk("rr_sel", {30'd0, tile_sel}, {30'd0, w});
      chk("rr_ui", {24'd0, tile_ui_in}, {24'd0, d});
      step();
      step();
      chk_rsp("rr_rsp", w, ~d);
    end

    // ---- fairness after wrap ----
    do_reset();
    req = 4'b0100;
    req_data = 32'h00330000;
    step();
    chk("fw_sel2", {30'd0, tile_sel}, 32'd2);
    step();
    step();
    chk_rsp("fw_rsp2", 2'd2, 8'hCC);
    req = 4'b0000;
    step();
    req = 4'b0101;
    req_data = 32'h00330055;
    step();
    chk("fw_wrap_sel", {30'd0, tile_sel}, 32'd0);
    step();
    step();
    chk_rsp("fw_rsp0", 2'd0, 8'hAA);
    step();
    chk("fw_next_sel", {30'd0, tile_sel}, 32'd2);

    // ---- back-to-back same requester ----
    do_reset();
    req = 4'b0010;
    req_data = 32'h00003C00;
    step();
    chk("bb_sel", {30'd0, tile_sel}, 32'd1);
    step();
    step();
    chk_rsp("bb_rsp1", 2'd1, 8'hC3);
    step();
    chk("bb_no_regrant", {31'd0, busy}, 32'd0);
    chk("bb_no_dup", {31'd0, rsp_valid}, 32'd0);
    step();
    chk("bb_regrant", {31'd0, busy}, 32'd1);
    chk("bb_regrant_sel", {30'd0, tile_sel}, 32'd1);
    step();
    step();
    chk_rsp("bb_rsp2", 2'd1, 8'hC3);
    req = 4'b0000;
    step();
    chk("bb_end", {31'd0, rsp_valid}, 32'd0);

    // ---- ena=0 during APPLY ----
    do_reset();
    req = 4'b0010;
    req_data = 32'h44335C11;
    step();
    chk("en_sel", {30'd0, tile_sel}, 32'd1);
    ena = 1'b0;
    req = 4'b1111;
    step();
    step();
    chk_rsp("en_rsp", 2'd1, 8'hA3);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("en_hold_busy", {31'd0, busy}, 32'd0);
      chk("en_hold_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    ena = 1'b1;
    step();
    chk("en_resume_sel", {30'd0, tile_sel}, 32'd2);
    chk("en_resume_ui", {24'd0, tile_ui_in}, 32'h33);

    // ---- async reset mid-APPLY ----
    do_reset();
    req = 4'b0100;
    req_data = 32'h66770000;
    step();
    step();
    step();
    chk_rsp("ar_rsp2", 2'd2, 8'h88);
    req = 4'b0000;
    step();
    req = 4'b1000;
    step();
    chk("ar_sel3", {30'd0, tile_sel}, 32'd3);
    chk("ar_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_sel0", {30'd0, tile_sel}, 32'd0);
    chk("ar_ui0", {24'd0, tile_ui_in}, 32'd0);
    chk("ar_busy0", {31'd0, busy}, 32'd0);
    chk("ar_rsp_valid0", {31'd0, rsp_valid}, 32'd0);
    chk("ar_rsp_id0", {30'd0, rsp_id}, 32'd0);
    chk("ar_rsp_data0", {24'd0, rsp_data}, 32'd0);
    step();
    chk("ar_no_rsp", {31'd0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    req = 4'b1110;
    step();
    chk("ar_ptr_reset_sel", {30'd0, tile_sel}, 32'd1);
    chk("ar_ptr_reset_busy", {31'd0, busy}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_microtile_io_arbiter
`default_nettype wire
